// File: rtl/irq_trap_sequencer_if.sv
// Bundles the CSR port, the core PC/trap handshake and the interrupt
// controller handshake of irq_trap_sequencer into one interface.
// "slave" is the sequencer's view; "master" is the core/controller side.
interface irq_trap_sequencer_if;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        mret_i;
    logic        irq_pending_i;
    logic [31:0] irq_cause_i;
    logic [31:0] mie_o;
    logic        irq_done_o;
    logic        trap_o;
    logic [31:0] trap_pc_o;
    logic        in_handler_o;

    modport slave (
        input  csr_we_i, csr_addr_i, csr_wdata_i, pc_i, stall_i, mret_i,
               irq_pending_i, irq_cause_i,
        output csr_rdata_o, mie_o, irq_done_o, trap_o, trap_pc_o, in_handler_o
    );

    modport master (
        output csr_we_i, csr_addr_i, csr_wdata_i, pc_i, stall_i, mret_i,
               irq_pending_i, irq_cause_i,
        input  csr_rdata_o, mie_o, irq_done_o, trap_o, trap_pc_o, in_handler_o
    );
endinterface

// File: rtl/irq_trap_sequencer.sv
// Machine-mode trap sequencer: accepts an interrupt, saves the PC/cause,
// redirects fetch to the handler, and on mret restores state, redirects
// back and pulses service-done. Also holds the machine interrupt CSRs.
module irq_trap_sequencer #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int unsigned HOLDOFF     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    irq_trap_sequencer_if.slave   bus
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [1:0]  HOLDOFF_INIT  = HOLDOFF[1:0];
    localparam logic [31:0] MTVEC_RESET   = {RESET_MTVEC[31:2], 1'b0, RESET_MTVEC[0]};

    typedef enum logic [1:0] {IDLE, ENTER, HANDLER, RETURN} state_t;

    state_t      state_r, state_next_s;
    logic        mstatus_mie_r, mstatus_mpie_r;
    logic [31:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r;
    logic [1:0]  holdoff_r;
    logic        accept_s, trap_s, done_s;
    logic [31:0] trap_pc_s, rdata_s;

    // Handler entry address: aligned base, plus 4*cause code in vectored mode.
    function automatic logic [31:0] trap_vector(input logic [31:0] tvec,
                                                input logic [4:0]  code);
        logic [31:0] offset;
        if (tvec[0]) begin
            offset = {25'd0, code, 2'b00};
        end else begin
            offset = 32'h0000_0000;
        end
        return {tvec[31:2], 2'b00} + offset;
    endfunction

    assign accept_s = (state_r == IDLE) && bus.irq_pending_i && mstatus_mie_r &&
                      !bus.stall_i && (holdoff_r == 2'd0);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and trap/done strobe decode.
    always_comb begin
        state_next_s = state_r;
        trap_s       = 1'b0;
        trap_pc_s    = 32'h0000_0000;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = ENTER;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ENTER: begin
                trap_s       = 1'b1;
                trap_pc_s    = trap_vector(mtvec_r, mcause_r[4:0]);
                state_next_s = HANDLER;
            end
            HANDLER: begin
                if (bus.mret_i) begin
                    state_next_s = RETURN;
                end else begin
                    state_next_s = HANDLER;
                end
            end
            RETURN: begin
                trap_s       = 1'b1;
                trap_pc_s    = mepc_r;
                done_s       = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Holdoff counter: armed on return, counts down through IDLE cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            holdoff_r <= 2'd0;
        end else if (state_r == RETURN) begin
            holdoff_r <= HOLDOFF_INIT;
        end else if ((state_r == IDLE) && (holdoff_r != 2'd0)) begin
            holdoff_r <= holdoff_r - 2'd1;
        end else begin
            holdoff_r <= holdoff_r;
        end
    end

    // Software-only CSRs: mie, mtvec, mscratch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mie_r      <= 32'h0000_0000;
            mtvec_r    <= MTVEC_RESET;
            mscratch_r <= 32'h0000_0000;
        end else if (bus.csr_we_i) begin
            case (bus.csr_addr_i)
                ADDR_MIE:      mie_r      <= bus.csr_wdata_i;
                ADDR_MTVEC:    mtvec_r    <= {bus.csr_wdata_i[31:2], 1'b0, bus.csr_wdata_i[0]};
                ADDR_MSCRATCH: mscratch_r <= bus.csr_wdata_i;
                default: begin
                    mie_r      <= mie_r;
                    mtvec_r    <= mtvec_r;
                    mscratch_r <= mscratch_r;
                end
            endcase
        end else begin
            mie_r      <= mie_r;
            mtvec_r    <= mtvec_r;
            mscratch_r <= mscratch_r;
        end
    end

    // Trap-state CSRs: hardware entry/return take priority over software writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mepc_r         <= 32'h0000_0000;
            mcause_r       <= 32'h0000_0000;
        end else if (accept_s) begin
            mepc_r         <= {bus.pc_i[31:2], 2'b00};
            mcause_r       <= bus.irq_cause_i;
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
        end else if (state_r == RETURN) begin
            mstatus_mie_r  <= mstatus_mpie_r;
            mstatus_mpie_r <= 1'b1;
        end else if (bus.csr_we_i) begin
            case (bus.csr_addr_i)
                ADDR_MSTATUS: begin
                    mstatus_mie_r  <= bus.csr_wdata_i[3];
                    mstatus_mpie_r <= bus.csr_wdata_i[7];
                end
                ADDR_MEPC:   mepc_r   <= {bus.csr_wdata_i[31:2], 2'b00};
                ADDR_MCAUSE: mcause_r <= bus.csr_wdata_i;
                default: begin
                    mstatus_mie_r  <= mstatus_mie_r;
                    mstatus_mpie_r <= mstatus_mpie_r;
                    mepc_r         <= mepc_r;
                    mcause_r       <= mcause_r;
                end
            endcase
        end else begin
            mstatus_mie_r  <= mstatus_mie_r;
            mstatus_mpie_r <= mstatus_mpie_r;
            mepc_r         <= mepc_r;
            mcause_r       <= mcause_r;
        end
    end

    // CSR read mux; unimplemented addresses read zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (bus.csr_addr_i)
            ADDR_MSTATUS:  rdata_s = {24'd0, mstatus_mpie_r, 3'b000, mstatus_mie_r, 3'b000};
            ADDR_MIE:      rdata_s = mie_r;
            ADDR_MTVEC:    rdata_s = mtvec_r;
            ADDR_MSCRATCH: rdata_s = mscratch_r;
            ADDR_MEPC:     rdata_s = mepc_r;
            ADDR_MCAUSE:   rdata_s = mcause_r;
            default:       rdata_s = 32'h0000_0000;
        endcase
    end

    assign bus.csr_rdata_o  = rdata_s;
    assign bus.mie_o        = mie_r;
    assign bus.trap_o       = trap_s;
    assign bus.trap_pc_o    = trap_pc_s;
    assign bus.irq_done_o   = done_s;
    assign bus.in_handler_o = (state_r != IDLE);
endmodule

// File: doc/irq_trap_sequencer.md
# irq_trap_sequencer

Machine-mode trap sequencer and interrupt CSR file between the core's PC/CSR logic and the interrupt controller. It takes the controller's pending request and cause, saves the interrupted PC, and redirects fetch to the handler. On `mret` it restores state, redirects fetch back, and pulses the controller's service-done input. It also owns `mstatus`/`mie`/`mtvec`/`mscratch`/`mepc`/`mcause` and drives `mie` into the controller.

## Interface
- `RESET_MTVEC`, 32'h0000_0000, reset value of `mtvec`.
- `HOLDOFF`, 1, IDLE cycles after RETURN during which new requests are not accepted (0..3).

- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `csr_we_i`  in  1  CSR write strobe.
- `csr_addr_i`  in  12  CSR address.
- `csr_wdata_i`  in  32  CSR write data.
- `csr_rdata_o`  out  32  CSR read data, combinational from `csr_addr_i`.
- `pc_i`  in  32  PC of the instruction to be interrupted.
- `stall_i`  in  1  core cannot take a trap this cycle.
- `mret_i`  in  1  `mret` retiring this cycle.
- `irq_pending_i`  in  1  request from the interrupt controller.
- `irq_cause_i`  in  32  cause word from the interrupt controller.
- `mie_o`  out  32  `mie` register, to the controller.
- `irq_done_o`  out  1  one-cycle service-done pulse to the controller.
- `trap_o`  out  1  one-cycle PC redirect strobe.
- `trap_pc_o`  out  32  redirect target; valid when `trap_o`=1, otherwise 0.
- `in_handler_o`  out  1  high in the ENTER, HANDLER and RETURN states.

## Operation
- CSRs:
  - `mstatus` 0x300: only MIE[3] and MPIE[7] are implemented; all other bits read 0.
  - `mie` 0x304: full 32-bit register.
  - `mtvec` 0x305: bit 1 reads 0; bit 0 is the mode (0 = direct, 1 = vectored).
  - `mscratch` 0x340.
  - `mepc` 0x341: bits [1:0] read 0.
  - `mcause` 0x342.
  - Any other address reads 0; writes to it are ignored.
- Reset:
  - All CSRs are 0, except `mtvec`=`RESET_MTVEC` with bit 1 cleared.
  - State is IDLE and the holdoff counter is 0.
  - All outputs are 0; `mie_o` is 0.
- States: IDLE, ENTER, HANDLER, RETURN.
- IDLE:
  - Accept when `irq_pending_i` & MIE & ~`stall_i` & holdoff counter==0.
  - On accept, at the edge: `mepc`←{`pc_i`[31:2],2'b00}; `mcause`←`irq_cause_i`; MPIE←MIE; MIE←0; next state ENTER.
- ENTER (exactly 1 cycle):
  - `trap_o`=1.
  - `trap_pc_o` = {`mtvec`[31:2],2'b00}, plus 4·`mcause`[4:0] when `mtvec`[0]=1 (modulo 2^32).
  - Next state HANDLER.
- HANDLER:
  - Waits for `mret_i`; `irq_pending_i` is ignored.
  - On `mret_i`, next state RETURN.
- RETURN (exactly 1 cycle):
  - `trap_o`=1, `trap_pc_o`=`mepc`, `irq_done_o`=1.
  - At the edge: MIE←MPIE, MPIE←1, holdoff counter←`HOLDOFF`; next state IDLE.
- Holdoff counter decrements once per IDLE cycle until it reaches 0. It gives the controller time to drop its stale request.
- `mret_i` outside HANDLER has no effect.
- CSR writes take effect at the edge in any state.
- Same-edge conflicts:
  - A hardware update (accept or RETURN) wins on `mepc`, `mcause` and `mstatus`.
  - Writes to other CSRs in the same cycle proceed.
- A software write of `mepc` in HANDLER changes the return target.
- A software write setting MIE in HANDLER does not cause nesting, because no acceptance is possible outside IDLE.
- Reset asserted mid-trap (any state): immediate return to reset values; no `irq_done_o` pulse.

## Timing
- Accept at edge T: `trap_o` is high during cycle T..T+1 (ENTER); HANDLER starts at T+1.
- `mret_i` sampled at edge M: RETURN during M..M+1, with `trap_o`=`irq_done_o`=1 for exactly that cycle.
- Earliest next accept, with `HOLDOFF`=1:
  - The edge ending the second IDLE cycle after RETURN.
  - The counter is 1 in the first IDLE cycle and 0 in the second.
- `trap_o` and `irq_done_o` are never high for two consecutive cycles.
- `csr_rdata_o` is combinational. A read in the same cycle as a write returns the old value.

## Test plan
- Reset release, `RESET_MTVEC`=0x100 → all reads return 0 except `mtvec`=0x100; outputs 0.
- Direct mode: `mtvec`=0x100, MIE=1, `mie`=0x1, pulse `irq_pending_i` with cause 0x8000_0003 and `pc_i`=0x2A4 → next cycle `trap_o`=1, `trap_pc_o`=0x100. Then `mepc`=0x2A4, `mcause`=0x8000_0003, `mstatus`=0x80.
- Vectored mode: `mtvec`=0x101, cause 5 → `trap_pc_o`=0x114.
- `mret_i` in HANDLER → one cycle with `trap_o`=1, `trap_pc_o`=0x2A4, `irq_done_o`=1. Afterwards `mstatus`=0x88.
- `irq_pending_i` held high continuously → no accept in the first IDLE cycle after RETURN; accept on the following edge.
- Blocked accepts:
  - `stall_i`=1 or MIE=0 with pending high → no `trap_o`.
  - Accept in the same cycle as a `csr_we_i` to `mepc` → `mepc`=`pc_i`.
  - `rst_ni` low in HANDLER → IDLE immediately, `irq_done_o` stays 0.
